// File: rtl/i2c_dbg_slave.sv
// I2C target that turns cmd/data frames into openMSP430 debug-register reads and writes.
// Optional build macro I2C_DBG_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_dbg_slave #(
    parameter logic [6:0] pCORE_ADDR  = 7'h51,
    parameter logic [6:0] pBCAST_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [5:0]  dbg_addr,
    output logic [15:0] dbg_din,
    output logic        dbg_bw,
    output logic        dbg_wr,
    output logic        dbg_rd,
    input  logic [15:0] dbg_dout,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Front end: synchronisers, optional filter, edge history. Idle bus level is high.
    logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic       scl_cur, sda_cur;
`ifdef I2C_DBG_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
`endif

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
`ifdef I2C_DBG_GLITCH_FILTER_EN
        scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
        scl_cur = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                  (scl_hist_q[1] & scl_hist_q[2]);
        sda_cur = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                  (sda_hist_q[1] & sda_hist_q[2]);
`else
        scl_cur = scl_sync_q[1];
        sda_cur = sda_sync_q[1];
`endif
        scl_prev_d = scl_cur;
        sda_prev_d = sda_cur;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
`ifdef I2C_DBG_GLITCH_FILTER_EN
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
`endif
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
`ifdef I2C_DBG_GLITCH_FILTER_EN
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
`endif
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_cur & ~scl_prev_q;
    assign scl_fall  = ~scl_cur & scl_prev_q;
    assign start_det = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
    assign stop_det  = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        rw_q, rw_d;
    logic        wr_flag_q, wr_flag_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic [5:0]  dbg_addr_q, dbg_addr_d;
    logic [15:0] dbg_din_q, dbg_din_d;
    logic        dbg_bw_q, dbg_bw_d;
    logic        dbg_wr_q, dbg_wr_d;
    logic        dbg_rd_q, dbg_rd_d;
    logic        busy_q, busy_d;

    logic [7:0] cur_byte;
    logic       addr_ok, last_byte;

    assign cur_byte  = byte_idx_q[0] ? rdata_q[15:8] : rdata_q[7:0];
    // Broadcast is write-only; a read needs a cmd frame latched since the last STOP.
    assign addr_ok   = ((shift_q[7:1] == pCORE_ADDR) && (!shift_q[0] || cmd_valid_q)) ||
                       ((shift_q[7:1] == pBCAST_ADDR) && !shift_q[0]);
    assign last_byte = dbg_bw_q ? (byte_idx_q == 2'd0) : (byte_idx_q == 2'd1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        rd_pend_d   = dbg_rd_q;
        byte_idx_d  = byte_idx_q;
        rw_d        = rw_q;
        wr_flag_d   = wr_flag_q;
        cmd_valid_d = cmd_valid_q;
        mack_d      = mack_q;
        sda_oe_d    = sda_oe_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_din_d   = dbg_din_q;
        dbg_bw_d    = dbg_bw_q;
        dbg_wr_d    = 1'b0;
        dbg_rd_d    = 1'b0;
        busy_d      = busy_q;

        if (rd_pend_q) rdata_d = dbg_dout;

        if (stop_det) begin
            state_d     = IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            cmd_valid_d = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else begin
            if (scl_rise && (state_q inside {ADDR, CMD, WDATA, RDATA})) begin
                shift_d   = {shift_q[6:0], sda_cur};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            if (scl_rise && state_q == RDATA_ACK) mack_d = ~sda_cur;

            // All SDA drive changes happen on the SCL fall, so SDA is stable while SCL is high.
            if (scl_fall) begin
                case (state_q)
                    ADDR: if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        rw_d      = shift_q[0];
                        if (addr_ok) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            dbg_rd_d = shift_q[0];
                        end else begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d    = RDATA;
                            byte_idx_d = 2'd0;
                            sda_oe_d   = ~rdata_q[7];
                        end else begin
                            state_d  = CMD;
                            sda_oe_d = 1'b0;
                        end
                    end
                    CMD: if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d   = 4'd0;
                        dbg_addr_d  = shift_q[5:0];
                        dbg_bw_d    = shift_q[6];
                        wr_flag_d   = shift_q[7];
                        cmd_valid_d = 1'b1;
                        sda_oe_d    = 1'b1;
                        state_d     = CMD_ACK;
                    end
                    CMD_ACK: begin
                        sda_oe_d   = 1'b0;
                        byte_idx_d = 2'd0;
                        state_d    = wr_flag_q ? WDATA : IGNORE;
                    end
                    WDATA: if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (byte_idx_q == 2'd0) begin
                            dbg_din_d = {8'h00, shift_q};
                            sda_oe_d  = 1'b1;
                            state_d   = WDATA_ACK;
                        end else if (byte_idx_q == 2'd1 && !dbg_bw_q) begin
                            dbg_din_d[15:8] = shift_q;
                            sda_oe_d        = 1'b1;
                            state_d         = WDATA_ACK;
                        end else begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                    WDATA_ACK: begin
                        sda_oe_d   = 1'b0;
                        state_d    = WDATA;
                        byte_idx_d = byte_idx_q + 2'd1;
                        dbg_wr_d   = last_byte;
                    end
                    RDATA: if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        state_d   = RDATA_ACK;
                    end else begin
                        sda_oe_d = ~cur_byte[3'd7 - bit_cnt_q[2:0]];
                    end
                    RDATA_ACK: if (mack_q && !dbg_bw_q && byte_idx_q == 2'd0) begin
                        byte_idx_d = 2'd1;
                        bit_cnt_d  = 4'd0;
                        sda_oe_d   = ~rdata_q[15];
                        state_d    = RDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = IGNORE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rdata_q     <= 16'h0000;
            rd_pend_q   <= 1'b0;
            byte_idx_q  <= 2'd0;
            rw_q        <= 1'b0;
            wr_flag_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            mack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            dbg_addr_q  <= 6'h00;
            dbg_din_q   <= 16'h0000;
            dbg_bw_q    <= 1'b0;
            dbg_wr_q    <= 1'b0;
            dbg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            rd_pend_q   <= rd_pend_d;
            byte_idx_q  <= byte_idx_d;
            rw_q        <= rw_d;
            wr_flag_q   <= wr_flag_d;
            cmd_valid_q <= cmd_valid_d;
            mack_q      <= mack_d;
            sda_oe_q    <= sda_oe_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_din_q   <= dbg_din_d;
            dbg_bw_q    <= dbg_bw_d;
            dbg_wr_q    <= dbg_wr_d;
            dbg_rd_q    <= dbg_rd_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign dbg_addr = dbg_addr_q;
    assign dbg_din  = dbg_din_q;
    assign dbg_bw   = dbg_bw_q;
    assign dbg_wr   = dbg_wr_q;
    assign dbg_rd   = dbg_rd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_dbg_slave.sv
// Directed bench for i2c_dbg_slave: bus-level I2C master tasks plus a strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_dbg_slave;

    localparam int Q = 8;
    localparam int H = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl_drv = 1'b1;
    logic        sda_drv = 1'b1;
    logic        scl_i, sda_i;
    logic        sda_oe;
    logic [5:0]  dbg_addr;
    logic [15:0] dbg_din;
    logic        dbg_bw, dbg_wr, dbg_rd, busy;
    logic [15:0] dbg_dout = 16'hBEEF;

    // Open-drain bus: either side can pull SDA low.
    assign scl_i = scl_drv;
    assign sda_i = sda_drv & ~sda_oe;

    i2c_dbg_slave dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .dbg_addr (dbg_addr),
        .dbg_din  (dbg_din),
        .dbg_bw   (dbg_bw),
        .dbg_wr   (dbg_wr),
        .dbg_rd   (dbg_rd),
        .dbg_dout (dbg_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Expected strobe record: {wr, rd, addr[5:0], bw, din[15:0]}
    logic [24:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        oe_seen = 1'b0;
    logic        busy_seen = 1'b0;
    logic [24:0] mon_act, mon_exp;

    function automatic logic [24:0] exp_wr(input logic [5:0] a, input logic bw, input logic [15:0] d);
        return {2'b10, a, bw, d};
    endfunction

    function automatic logic [24:0] exp_rd(input logic [5:0] a, input logic bw);
        return {2'b01, a, bw, 16'h0000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes the debug port.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (dbg_wr || dbg_rd) begin
                mon_act = {dbg_wr, dbg_rd, dbg_addr, dbg_bw, dbg_wr ? dbg_din : 16'h0000};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected: got %h expected none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        bad++;
                        $display("FAIL strobe: got %h expected %h", mon_act, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        sda_drv = 1'b0; wait_clks(Q);
        scl_drv = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(Q);
        sda_drv = 1'b1; wait_clks(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_drv = b;    wait_clks(Q);
        scl_drv = 1'b1; wait_clks(H);
        scl_drv = 1'b0; wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        sda_drv = 1'b1; wait_clks(Q);
        scl_drv = 1'b1; wait_clks(H / 2);
        acked = (sda_i == 1'b0);
        wait_clks(H / 2);
        scl_drv = 1'b0; wait_clks(Q);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        sda_drv = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clks(Q);
            scl_drv = 1'b1; wait_clks(H / 2);
            b[i] = sda_i;
            wait_clks(H / 2);
            scl_drv = 1'b0; wait_clks(Q);
        end
        put_bit(!ack);
    endtask

    logic       a;
    logic [7:0] rb;
    logic       exp_glitch;

    initial begin
        wait_clks(5);
        chk("reset_outs_in_reset", {sda_oe, dbg_wr, dbg_rd, busy, dbg_bw, dbg_addr, dbg_din}, 32'h0);
        reset_n = 1'b1;
        wait_clks(5);
        chk("reset_outs_after", {sda_oe, dbg_wr, dbg_rd, busy, dbg_bw, dbg_addr, dbg_din}, 32'h0);

        // 8-bit write to addr 0x02
        exp_q.push_back(exp_wr(6'h02, 1'b1, 16'h0002));
        i2c_start();
        send_byte(8'hA2, a); chk("t1_addr_ack", a, 1);
        chk("t1_busy_mid", busy, 1);
        send_byte(8'hC2, a); chk("t1_cmd_ack", a, 1);
        send_byte(8'h02, a); chk("t1_data_ack", a, 1);
        i2c_stop();
        wait_clks(4);
        chk("t1_busy_after_stop", busy, 0);

        // 16-bit write LSB first
        exp_q.push_back(exp_wr(6'h05, 1'b0, 16'h1234));
        i2c_start();
        send_byte(8'hA2, a); chk("t2_addr_ack", a, 1);
        send_byte(8'h85, a); chk("t2_cmd_ack", a, 1);
        send_byte(8'h34, a); chk("t2_lo_ack", a, 1);
        send_byte(8'h12, a); chk("t2_hi_ack", a, 1);
        i2c_stop();

        // 16-bit read via repeated START
        i2c_start();
        send_byte(8'hA2, a); chk("t3_addr_ack", a, 1);
        send_byte(8'h06, a); chk("t3_cmd_ack", a, 1);
        exp_q.push_back(exp_rd(6'h06, 1'b0));
        i2c_start();
        send_byte(8'hA3, a); chk("t3_raddr_ack", a, 1);
        read_byte(1'b1, rb); chk("t3_rd_lo", rb, 8'hEF);
        read_byte(1'b0, rb); chk("t3_rd_hi", rb, 8'hBE);
        i2c_stop();

        // Foreign address, broadcast write, broadcast read
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'hA4, a); chk("t4_foreign_nack", a, 0);
        send_byte(8'hC2, a);
        i2c_stop();
        wait_clks(2);
        chk("t4_foreign_oe_quiet", oe_seen, 0);
        exp_q.push_back(exp_wr(6'h03, 1'b1, 16'h007E));
        i2c_start();
        send_byte(8'hA0, a); chk("t4_bcast_ack", a, 1);
        send_byte(8'hC3, a); chk("t4_bcast_cmd_ack", a, 1);
        send_byte(8'h7E, a); chk("t4_bcast_data_ack", a, 1);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, a); chk("t4_bcast_read_nack", a, 0);
        i2c_stop();

        // Read without a prior cmd frame since STOP
        i2c_start();
        send_byte(8'hA3, a); chk("read_no_cmd_nack", a, 0);
        i2c_stop();

        // Surplus data byte on an 8-bit write is refused
        exp_q.push_back(exp_wr(6'h01, 1'b1, 16'h0077));
        i2c_start();
        send_byte(8'hA2, a);
        send_byte(8'hC1, a);
        send_byte(8'h77, a); chk("extra_first_ack", a, 1);
        send_byte(8'h55, a); chk("extra_byte_nack", a, 0);
        i2c_stop();
        chk("extra_din_kept", dbg_din, 16'h0077);

        // Abort a partial high byte with repeated START, then a clean frame
        i2c_start();
        send_byte(8'hA2, a);
        send_byte(8'h85, a);
        send_byte(8'h34, a); chk("t5_lo_ack", a, 1);
        put_bit(1'b0); put_bit(1'b0); put_bit(1'b0); put_bit(1'b1);
        exp_q.push_back(exp_wr(6'h04, 1'b1, 16'h005A));
        i2c_start();
        send_byte(8'hA2, a); chk("t5_restart_ack", a, 1);
        send_byte(8'hC4, a);
        send_byte(8'h5A, a); chk("t5_data_ack", a, 1);
        i2c_stop();

        // Reset asserted while the DUT drives a read bit
        dbg_dout = 16'h0000;
        i2c_start();
        send_byte(8'hA2, a);
        send_byte(8'h06, a);
        exp_q.push_back(exp_rd(6'h06, 1'b0));
        i2c_start();
        send_byte(8'hA3, a); chk("t5_rd_ack", a, 1);
        wait_clks(2);
        chk("t5_rd_oe_driven", sda_oe, 1);
        #2 reset_n = 1'b0;
        #1 chk("t5_reset_async_oe", sda_oe, 0);
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        wait_clks(4);
        chk("t5_reset_busy", busy, 0);
        reset_n = 1'b1;
        wait_clks(10);

        // Single-clock SDA low pulse while SCL is high
`ifdef I2C_DBG_GLITCH_FILTER_EN
        exp_glitch = 1'b0;
`else
        exp_glitch = 1'b1;
`endif
        busy_seen = 1'b0;
        @(negedge clk) sda_drv = 1'b0;
        @(negedge clk) sda_drv = 1'b1;
        wait_clks(20);
        chk("glitch_start_seen", busy_seen, exp_glitch);
        chk("glitch_idle_after", busy, 0);

        wait_clks(20);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
